// File: rtl/trng_pool_harvester_if.sv
// ---------------------------------------------------------------------------
// trng_pool_harvester_if
// Bundles the sample input, read-out handshake and status signals of the
// entropy pool harvester. Clock and reset stay plain ports on the module.
//
// Signals:
//   en           harvest enable
//   sample       sensor sample (SAMPLE_W bits)
//   sample_stb   one-cycle strobe: sample is new
//   read_result  current output word (WORD_W bits)
//   read_valid   read_result holds a valid word
//   read_ready   consumer accepts the word
//   bit_count    debiased bits currently in the pool
//   drop_cnt     samples dropped while the serializer was busy (saturating)
//   health_fail  sticky repetition-count failure
//
// Modports:
//   master  environment side (sensor master / read-out wrapper)
//   slave   harvester side
// ---------------------------------------------------------------------------
interface trng_pool_harvester_if #(
    parameter int SAMPLE_W  = 12,
    parameter int POOL_BITS = 512,
    parameter int WORD_W    = 32
) ();
    localparam int CNT_W = $clog2(POOL_BITS + 1);

    logic                en;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_stb;
    logic [WORD_W-1:0]   read_result;
    logic                read_valid;
    logic                read_ready;
    logic [CNT_W-1:0]    bit_count;
    logic [7:0]          drop_cnt;
    logic                health_fail;

    modport master (
        output en, sample, sample_stb, read_ready,
        input  read_result, read_valid, bit_count, drop_cnt, health_fail
    );

    modport slave (
        input  en, sample, sample_stb, read_ready,
        output read_result, read_valid, bit_count, drop_cnt, health_fail
    );
endinterface

// File: rtl/trng_pool_harvester.sv
// ---------------------------------------------------------------------------
// trng_pool_harvester
// Harvests TAP_BITS low-order bits from each strobed temperature sample,
// von Neumann debiases the raw bit stream, accumulates the debiased bits in
// a POOL_BITS entropy pool and streams the full pool out as WORD_W-bit words
// over a valid/ready handshake (oldest bit = MSB of word 0).
//
// Ports:
//   SCLK  system clock, rising edge
//   RST   asynchronous reset, active-low
//   bus   trng_pool_harvester_if.slave (enable, sample/strobe, read-out
//         handshake, bit_count, drop_cnt, health_fail)
//
// Optional build macro:
//   TRNG_HEALTH_EN  adds a repetition-count health test on the raw bits.
//                   When undefined no run counter exists and health_fail
//                   is tied low.
// ---------------------------------------------------------------------------
module trng_pool_harvester #(
    parameter int SAMPLE_W  = 12,
    parameter int TAP_BITS  = 1,
    parameter int POOL_BITS = 512,
    parameter int WORD_W    = 32,
    parameter int REP_LIMIT = 16
) (
    input logic                  SCLK,
    input logic                  RST,
    trng_pool_harvester_if.slave bus
);
    localparam int CNT_W  = $clog2(POOL_BITS + 1);
    localparam int NWORDS = POOL_BITS / WORD_W;
    localparam int K_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int SER_W  = $clog2(TAP_BITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    if (TAP_BITS < 1 || TAP_BITS > SAMPLE_W || (POOL_BITS % WORD_W) != 0 ||
        POOL_BITS < 2 || REP_LIMIT < 2) begin : g_bad_params
        $error("trng_pool_harvester: illegal parameter combination");
    end

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]          state;
    logic [POOL_BITS-1:0] pool;
    logic [CNT_W-1:0]    bit_count;
    logic [7:0]          drop_cnt;
    logic                read_valid;
    logic [K_W-1:0]      word_idx;

    // The whole sample is loaded so every sample bit has a reader; only the
    // first TAP_BITS of it are ever shifted out, as ser_left_p0 counts them.
    logic [SAMPLE_W-1:0] ser_bits_p0;
    logic [SER_W-1:0]    ser_left_p0;
    logic                pair_have_p1;
    logic                pair_first_p1;

    logic pool_full;
    logic halted;
    logic health_trip;
    logic fill_go;
    logic ser_free;
    logic vld_p0;
    logic raw_bit_p0;
    logic vld_p1;
    logic clr_harvest;
    logic accept;
    logic last_word;

    always_comb begin
        pool_full   = (bit_count == CNT_W'(POOL_BITS));
        fill_go     = bus.en && (state == ST_FILL) && !pool_full && !halted;
        // A strobe landing on the last serializer bit reloads seamlessly.
        ser_free    = (ser_left_p0 == '0) || (ser_left_p0 == SER_W'(1));
        vld_p0      = fill_go && (ser_left_p0 != '0);
        raw_bit_p0  = ser_bits_p0[0];
        // 01 -> 0, 10 -> 1: the debiased bit equals the first bit of the pair.
        vld_p1      = vld_p0 && pair_have_p1 && (pair_first_p1 != raw_bit_p0);
        clr_harvest = !bus.en || (state != ST_FILL) || pool_full || halted || health_trip;
        accept      = read_valid && bus.read_ready;
        last_word   = accept && (word_idx == K_W'(NWORDS - 1));
    end

`ifdef TRNG_HEALTH_EN
    localparam int RUN_W = $clog2(REP_LIMIT + 1);

    logic             health_fail;
    logic             run_bit;
    logic [RUN_W-1:0] run_len;

    always_comb begin
        health_trip = vld_p0 && (run_bit == raw_bit_p0) &&
                      (run_len == RUN_W'(REP_LIMIT - 1));
        halted      = health_fail;
    end

    // Run length of identical raw bits, restarted on every change and
    // whenever the block falls back to IDLE.
    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            run_bit <= 1'b0;
            run_len <= '0;
        end else if (!bus.en || state == ST_IDLE) begin
            run_bit <= 1'b0;
            run_len <= '0;
        end else if (vld_p0) begin
            if (run_len != '0 && run_bit == raw_bit_p0) begin
                if (run_len != RUN_W'(REP_LIMIT))
                    run_len <= run_len + RUN_W'(1);
            end else begin
                run_bit <= raw_bit_p0;
                run_len <= RUN_W'(1);
            end
        end
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST)
            health_fail <= 1'b0;
        else if (!bus.en)
            health_fail <= 1'b0;
        else if (health_trip)
            health_fail <= 1'b1;
    end

    assign bus.health_fail = health_fail;
`else
    always_comb begin
        health_trip = 1'b0;
        halted      = 1'b0;
    end

    assign bus.health_fail = 1'b0;
`endif

    // Control FSM
    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else if (!bus.en) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state <= ST_FILL;
                ST_FILL:  if (pool_full) state <= ST_DRAIN;
                ST_DRAIN: if (last_word) state <= ST_FILL;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            read_valid <= 1'b0;
            word_idx   <= '0;
        end else if (!bus.en || health_trip) begin
            read_valid <= 1'b0;
            word_idx   <= '0;
        end else if (state == ST_FILL && pool_full) begin
            read_valid <= 1'b1;
            word_idx   <= '0;
        end else if (last_word) begin
            read_valid <= 1'b0;
            word_idx   <= '0;
        end else if (accept) begin
            word_idx   <= word_idx + K_W'(1);
        end
    end

    // Stage 0: serializer, one raw bit per cycle, bit 0 first
    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            ser_bits_p0 <= '0;
            ser_left_p0 <= '0;
        end else if (clr_harvest) begin
            ser_bits_p0 <= '0;
            ser_left_p0 <= '0;
        end else if (bus.sample_stb && ser_free) begin
            ser_bits_p0 <= bus.sample;
            ser_left_p0 <= SER_W'(TAP_BITS);
        end else if (ser_left_p0 != '0) begin
            ser_bits_p0 <= ser_bits_p0 >> 1;
            ser_left_p0 <= ser_left_p0 - SER_W'(1);
        end
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST)
            drop_cnt <= 8'd0;
        else if (fill_go && bus.sample_stb && !ser_free)
            drop_cnt <= sat_inc8(drop_cnt);
    end

    // Stage 1: von Neumann pairing of raw bits in arrival order
    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            pair_have_p1  <= 1'b0;
            pair_first_p1 <= 1'b0;
        end else if (clr_harvest) begin
            pair_have_p1  <= 1'b0;
            pair_first_p1 <= 1'b0;
        end else if (vld_p0) begin
            if (!pair_have_p1) begin
                pair_have_p1  <= 1'b1;
                pair_first_p1 <= raw_bit_p0;
            end else begin
                pair_have_p1  <= 1'b0;
            end
        end
    end

    // Stage 2: pool accumulation and word-wise drain from the MSB end
    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST)
            pool <= '0;
        else if (health_trip)
            pool <= '0;
        else if (vld_p1)
            pool <= {pool[POOL_BITS-2:0], pair_first_p1};
        else if (accept && bus.en)
            pool <= pool << WORD_W;
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST)
            bit_count <= '0;
        else if (!bus.en || health_trip || last_word)
            bit_count <= '0;
        else if (vld_p1)
            bit_count <= bit_count + CNT_W'(1);
    end

    assign bus.read_result = read_valid ? pool[POOL_BITS-1 -: WORD_W] : '0;
    assign bus.read_valid  = read_valid;
    assign bus.bit_count   = bit_count;
    assign bus.drop_cnt    = drop_cnt;
endmodule
